reset_sequencer: RTL and testbench

Parametrised successor to the single-output boot reset generator. It holds a set of CHANNELS active-high domain resets after power-up, then releases them one at a time in index order. It also restarts the sequence on a debounced external button or a software reset request, and records the last reset cause. It sits in the FPGA top level between the board reset/button pins and the SoC and peripheral reset inputs.

---
 rtl/reset_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds CHANNELS resets after POR, button or software
// restart, then releases them one by one in index order.
module reset_sequencer #(
  parameter int CHANNELS        = 4,
  parameter int POR_CYCLES      = 20,
  parameter int SW_HOLD_CYCLES  = 4,
  parameter int STAGE_GAP       = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ext_reset_i,
  input  logic                sw_reset_req_i,
  output logic [CHANNELS-1:0] reset_o,
  output logic                ready_o,
  output logic [1:0]          cause_o,
  output logic [7:0]          reset_count_o
);

  localparam int MAX_AB  = (POR_CYCLES > SW_HOLD_CYCLES) ? POR_CYCLES : SW_HOLD_CYCLES;
  localparam int MAX_CD  = (STAGE_GAP > DEBOUNCE_CYCLES) ? STAGE_GAP : DEBOUNCE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int STG_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CW-1:0]       POR_LEN    = CW'(POR_CYCLES);
  localparam logic [CW-1:0]       SW_LEN     = CW'(SW_HOLD_CYCLES);
  localparam logic [CW-1:0]       GAP_LAST   = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0]       DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [STG_W-1:0]    LAST_STAGE = STG_W'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] ONE_HOT0   = CHANNELS'(1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, hold_len, hold_len_nxt;
  logic [STG_W-1:0] stage, stage_nxt;
  logic [CHANNELS-1:0] reset_nxt;
  logic          ready_nxt;
  logic [1:0]    cause_nxt;
  logic [7:0]    count_nxt;

  logic          ext_meta, ext_s, ext_db, ext_db_d, sw_prev;
  logic [CW-1:0] db_cnt;
  logic          db_rise, sw_edge;

  // Button synchroniser, debouncer and edge-detect history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_meta <= 1'b0;
      ext_s    <= 1'b0;
      ext_db   <= 1'b0;
      ext_db_d <= 1'b0;
      db_cnt   <= '0;
      sw_prev  <= 1'b0;
    end else begin
      ext_meta <= ext_reset_i;
      ext_s    <= ext_meta;
      ext_db_d <= ext_db;
      sw_prev  <= sw_reset_req_i;
      if (ext_s == ext_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        ext_db <= ext_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  assign db_rise = ext_db & ~ext_db_d;
  assign sw_edge = sw_reset_req_i & ~sw_prev;

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HOLD;
      cnt           <= '0;
      stage         <= '0;
      hold_len      <= POR_LEN;
      reset_o       <= '1;
      ready_o       <= 1'b0;
      cause_o       <= CAUSE_POR;
      reset_count_o <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      stage         <= stage_nxt;
      hold_len      <= hold_len_nxt;
      reset_o       <= reset_nxt;
      ready_o       <= ready_nxt;
      cause_o       <= cause_nxt;
      reset_count_o <= count_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stage_nxt    = stage;
    hold_len_nxt = hold_len;
    reset_nxt    = reset_o;
    ready_nxt    = ready_o;
    cause_nxt    = cause_o;
    count_nxt    = reset_count_o;

    if ((state != HOLD) && (db_rise || sw_edge)) begin
      // Button wins over software when both arrive together
      state_nxt = HOLD;
      cnt_nxt   = '0;
      stage_nxt = '0;
      reset_nxt = '1;
      ready_nxt = 1'b0;
      count_nxt = (reset_count_o == 8'hFF) ? 8'hFF : reset_count_o + 8'd1;
      if (db_rise) begin
        hold_len_nxt = POR_LEN;
        cause_nxt    = CAUSE_EXT;
      end else begin
        hold_len_nxt = SW_LEN;
        cause_nxt    = CAUSE_SW;
      end
    end else begin
      case (state)
        HOLD: begin
          reset_nxt = '1;
          ready_nxt = 1'b0;
          if (db_rise) begin
            cnt_nxt      = '0;
            hold_len_nxt = POR_LEN;
            cause_nxt    = CAUSE_EXT;
          end else if (ext_db) begin
            cnt_nxt = '0;
          end else if (cnt == hold_len - CW'(1)) begin
            cnt_nxt   = '0;
            stage_nxt = '0;
            if (CHANNELS == 1) begin
              state_nxt = RUN;
              reset_nxt = '0;
              ready_nxt = 1'b1;
            end else begin
              state_nxt = RELEASE;
              reset_nxt = ~ONE_HOT0;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RELEASE: begin
          ready_nxt = 1'b0;
          if (cnt == GAP_LAST) begin
            cnt_nxt   = '0;
            stage_nxt = stage + STG_W'(1);
            reset_nxt = reset_o & ~(ONE_HOT0 << stage_nxt);
            if (stage_nxt == LAST_STAGE) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end else begin
              state_nxt = RELEASE;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RUN: begin
          reset_nxt = '0;
          ready_nxt = 1'b1;
        end
        default: begin
          state_nxt    = HOLD;
          cnt_nxt      = '0;
          stage_nxt    = '0;
          hold_len_nxt = POR_LEN;
          reset_nxt    = '1;
          ready_nxt    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a cycle-stamped scoreboard of expected output snapshots,
// plus direct checks around asynchronous reset and counter saturation.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst0, rst1, ext0, ext1, sw0, sw1;
  logic [3:0] r0;
  logic [0:0] r1;
  logic       rdy0, rdy1;
  logic [1:0] cause0, cause1;
  logic [7:0] cnt0, cnt1;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned base = 0;

  typedef struct {
    string       tag;
    int unsigned at;
    bit          dut;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  reset_sequencer u0 (
    .clk(clk), .reset(rst0), .ext_reset_i(ext0), .sw_reset_req_i(sw0),
    .reset_o(r0), .ready_o(rdy0), .cause_o(cause0), .reset_count_o(cnt0)
  );

  reset_sequencer #(.CHANNELS(1), .STAGE_GAP(1)) u1 (
    .clk(clk), .reset(rst1), .ext_reset_i(ext1), .sw_reset_req_i(sw1),
    .reset_o(r1), .ready_o(rdy1), .cause_o(cause1), .reset_count_o(cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pack(input logic [3:0] r, input logic rd,
                                       input logic [1:0] c, input logic [7:0] k);
    return {17'd0, r, rd, c, k};
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Snapshot {reset_o, ready_o, cause_o, reset_count_o} expected after edge base+n
  task automatic expect_at(input bit dut, input string tag, input int unsigned n,
                           input logic [3:0] r, input logic rd, input logic [1:0] c,
                           input logic [7:0] k);
    sb_entry_t e;
    e.tag = tag;
    e.at  = base + n;
    e.dut = dut;
    e.exp = pack(r, rd, c, k);
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check_value(tag, sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin : scoreboard
    sb_entry_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.dut)
        check_value(e.tag, pack({3'b000, r1}, rdy1, cause1, cnt1), e.exp);
      else
        check_value(e.tag, pack(r0, rdy0, cause0, cnt0), e.exp);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    ext0 = 1'b0; ext1 = 1'b0; sw0 = 1'b0; sw1 = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_reset_o", {28'd0, r0}, 32'h0000000F);
    check_value("rst_ready",   {31'd0, rdy0}, 32'd0);
    check_value("rst_cause",   {30'd0, cause0}, 32'd0);
    check_value("rst_count",   {24'd0, cnt0}, 32'd0);
    check_value("rst1_reset_o", {31'd0, r1}, 32'd1);

    // Power-up release sequence
    rst0 = 1'b0; base = cyc;
    expect_at(1'b0, "por_e1",  1,  4'b1111, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e19", 19, 4'b1111, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e20", 20, 4'b1110, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e27", 27, 4'b1110, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e28", 28, 4'b1100, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e35", 35, 4'b1100, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e36", 36, 4'b1000, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e43", 43, 4'b1000, 1'b0, 2'b00, 8'd0);
    expect_at(1'b0, "por_e44", 44, 4'b0000, 1'b1, 2'b00, 8'd0);
    drain("por_drain");

    // Button held 40 cycles: restart 19 edges in, release 20 edges after ext_db falls
    @(negedge clk); ext0 = 1'b1; base = cyc;
    expect_at(1'b0, "btn_e18",  18,  4'b0000, 1'b1, 2'b00, 8'd0);
    expect_at(1'b0, "btn_e19",  19,  4'b1111, 1'b0, 2'b01, 8'd1);
    expect_at(1'b0, "btn_e77",  77,  4'b1111, 1'b0, 2'b01, 8'd1);
    expect_at(1'b0, "btn_e78",  78,  4'b1110, 1'b0, 2'b01, 8'd1);
    expect_at(1'b0, "btn_e86",  86,  4'b1100, 1'b0, 2'b01, 8'd1);
    expect_at(1'b0, "btn_e94",  94,  4'b1000, 1'b0, 2'b01, 8'd1);
    expect_at(1'b0, "btn_e102", 102, 4'b0000, 1'b1, 2'b01, 8'd1);
    repeat (40) @(negedge clk);
    ext0 = 1'b0;
    drain("btn_drain");

    // Short glitch is rejected
    @(negedge clk); ext0 = 1'b1; base = cyc;
    expect_at(1'b0, "glitch_e5",  5,  4'b0000, 1'b1, 2'b01, 8'd1);
    expect_at(1'b0, "glitch_e15", 15, 4'b0000, 1'b1, 2'b01, 8'd1);
    expect_at(1'b0, "glitch_e30", 30, 4'b0000, 1'b1, 2'b01, 8'd1);
    repeat (10) @(negedge clk);
    ext0 = 1'b0;
    drain("glitch_drain");

    // Software request held 100 cycles: one restart with 4-cycle hold
    @(negedge clk); sw0 = 1'b1; base = cyc;
    expect_at(1'b0, "sw_e1",  1,  4'b1111, 1'b0, 2'b10, 8'd2);
    expect_at(1'b0, "sw_e4",  4,  4'b1111, 1'b0, 2'b10, 8'd2);
    expect_at(1'b0, "sw_e5",  5,  4'b1110, 1'b0, 2'b10, 8'd2);
    expect_at(1'b0, "sw_e13", 13, 4'b1100, 1'b0, 2'b10, 8'd2);
    expect_at(1'b0, "sw_e21", 21, 4'b1000, 1'b0, 2'b10, 8'd2);
    expect_at(1'b0, "sw_e28", 28, 4'b1000, 1'b0, 2'b10, 8'd2);
    expect_at(1'b0, "sw_e29", 29, 4'b0000, 1'b1, 2'b10, 8'd2);
    expect_at(1'b0, "sw_e99", 99, 4'b0000, 1'b1, 2'b10, 8'd2);
    repeat (100) @(negedge clk);
    sw0 = 1'b0;
    drain("sw_drain");

    // Button and software on the same cycle; later software edge during HOLD ignored
    @(negedge clk); ext0 = 1'b1; base = cyc;
    expect_at(1'b0, "both_e18", 18, 4'b0000, 1'b1, 2'b10, 8'd2);
    expect_at(1'b0, "both_e19", 19, 4'b1111, 1'b0, 2'b01, 8'd3);
    expect_at(1'b0, "both_e57", 57, 4'b1111, 1'b0, 2'b01, 8'd3);
    expect_at(1'b0, "both_e58", 58, 4'b1110, 1'b0, 2'b01, 8'd3);
    expect_at(1'b0, "both_e66", 66, 4'b1100, 1'b0, 2'b01, 8'd3);
    expect_at(1'b0, "both_e74", 74, 4'b1000, 1'b0, 2'b01, 8'd3);
    expect_at(1'b0, "both_e82", 82, 4'b0000, 1'b1, 2'b01, 8'd3);
    repeat (18) @(negedge clk); sw0 = 1'b1;
    repeat (2)  @(negedge clk); ext0 = 1'b0;
    repeat (5)  @(negedge clk); sw0 = 1'b0;
    repeat (5)  @(negedge clk); sw0 = 1'b1;
    repeat (10) @(negedge clk); sw0 = 1'b0;
    drain("both_drain");

    // Async reset mid-release with two bits cleared
    @(negedge clk); sw0 = 1'b1; base = cyc;
    expect_at(1'b0, "mid_e12", 12, 4'b1110, 1'b0, 2'b10, 8'd4);
    expect_at(1'b0, "mid_e16", 16, 4'b1100, 1'b0, 2'b10, 8'd4);
    repeat (2)  @(negedge clk); sw0 = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst0 = 1'b1;
    #1;
    check_value("async_reset_o", {28'd0, r0}, 32'h0000000F);
    check_value("async_ready",   {31'd0, rdy0}, 32'd0);
    check_value("async_cause",   {30'd0, cause0}, 32'd0);
    check_value("async_count",   {24'd0, cnt0}, 32'd0);
    @(negedge clk); rst0 = 1'b0; base = cyc;
    expect_at(1'b0, "repor_e20", 20, 4'b1110, 1'b0, 2'b00, 8'd0);
    drain("repor_drain");

    // Single-channel, unit-gap instance
    @(negedge clk); rst1 = 1'b0; base = cyc;
    expect_at(1'b1, "one_e19", 19, 4'b0001, 1'b0, 2'b00, 8'd0);
    expect_at(1'b1, "one_e20", 20, 4'b0000, 1'b1, 2'b00, 8'd0);
    drain("one_drain");

    for (int k = 1; k <= 300; k++) begin
      @(negedge clk); sw1 = 1'b1;
      if (k == 1) begin
        base = cyc;
        expect_at(1'b1, "one_sw_e1", 1, 4'b0001, 1'b0, 2'b10, 8'd1);
        expect_at(1'b1, "one_sw_e4", 4, 4'b0001, 1'b0, 2'b10, 8'd1);
        expect_at(1'b1, "one_sw_e5", 5, 4'b0000, 1'b1, 2'b10, 8'd1);
      end
      @(negedge clk); sw1 = 1'b0;
      repeat (6) @(negedge clk);
      if (k == 254) check_value("count_254", {24'd0, cnt1}, 32'd254);
      if (k == 255) check_value("count_255", {24'd0, cnt1}, 32'd255);
    end
    check_value("count_sat",   {24'd0, cnt1}, 32'd255);
    check_value("sat_ready",   {31'd0, rdy1}, 32'd1);
    check_value("sat_reset_o", {31'd0, r1}, 32'd0);
    check_value("sat_cause",   {30'd0, cause1}, 32'd2);
    drain("sat_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
